// File: rtl/idct_transpose_if.sv
// Stream bus for the IDCT transpose buffer: row-major samples in, column-major
// saturated samples out, with block mode and framing qualifiers.
interface idct_transpose_if #(
  parameter int DW_IN  = 17,
  parameter int DW_OUT = 16
);
  logic [1:0]               mode;
  logic                     in_valid;
  logic signed [DW_IN-1:0]  in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DW_OUT-1:0] out_data;
  logic                     out_ready;
  logic                     out_first;
  logic                     out_last;
  logic [1:0]               out_mode;
  logic                     out_sat;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, out_mode, out_sat
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, out_mode, out_sat
  );
endinterface

// File: rtl/idct_transpose.sv
// Ping-pong transpose buffer between the row and column IDCT passes: fills one
// bank row-major while draining the other column-major with 16-bit saturation.
module idct_transpose #(
  parameter int DW_IN  = 17,
  parameter int DW_OUT = 16,
  parameter int N_MAX  = 8
) (
  input logic             clk,
  input logic             rst,
  idct_transpose_if.slave bus
);
  localparam int AW = $clog2(N_MAX);
  localparam logic signed [DW_IN-1:0] SAT_MAX = DW_IN'((2 ** (DW_OUT - 1)) - 1);
  localparam logic signed [DW_IN-1:0] SAT_MIN = DW_IN'(-(2 ** (DW_OUT - 1)));

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  logic [1:0]  bmode_q [2];
  logic        wr_ptr, wr_ptr_d, rd_ptr;
  logic        in_ready_q, in_ready_d;
  logic [AW-1:0] wr_row, wr_col, rd_row, rd_col, wr_lim, rd_lim;
  logic [DW_IN-1:0] mem [2*N_MAX*N_MAX];

  logic                     s1_valid, s1_first, s1_last, s1_bank;
  logic [1:0]               s1_mode;
  logic signed [DW_IN-1:0]  s1_data;
  logic                     out_valid_q, out_first_q, out_last_q, out_sat_q, out_bank_q;
  logic [1:0]               out_mode_q;
  logic signed [DW_OUT-1:0] out_data_q, sat_data;
  logic                     sat_flag;

  logic wr_en, wr_done, out_load, s1_adv, rd_issue, rd_done, release_blk;

  // Until the first write lands, the block size comes from the live mode input.
  assign wr_lim = ((state_q[wr_ptr] == EMPTY) ? bus.mode[0] : bmode_q[wr_ptr][0])
                  ? AW'(N_MAX - 1) : AW'(N_MAX / 2 - 1);
  assign rd_lim = bmode_q[rd_ptr][0] ? AW'(N_MAX - 1) : AW'(N_MAX / 2 - 1);

  assign wr_en       = bus.in_valid && in_ready_q;
  assign wr_done     = wr_en && (wr_row == wr_lim) && (wr_col == wr_lim);
  assign out_load    = !out_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid || out_load;
  assign rd_issue    = s1_adv && (state_q[rd_ptr] == FULL || state_q[rd_ptr] == DRAINING);
  assign rd_done     = rd_issue && (rd_row == rd_lim) && (rd_col == rd_lim);
  assign release_blk = out_valid_q && bus.out_ready && out_last_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr;
    if (wr_en)   state_d[wr_ptr] = wr_done ? FULL : FILLING;
    if (wr_done) wr_ptr_d = ~wr_ptr;
    if (rd_issue && state_q[rd_ptr] == FULL) state_d[rd_ptr] = DRAINING;
    if (release_blk) state_d[out_bank_q] = EMPTY;
    in_ready_d = (state_d[wr_ptr_d] == FILLING) ||
                 (state_d[wr_ptr_d] == EMPTY && !bus.mode[1]);
  end

  always_comb begin
    sat_flag = 1'b0;
    sat_data = DW_OUT'(s1_data);
    if (s1_data > SAT_MAX) begin
      sat_data = DW_OUT'(SAT_MAX);
      sat_flag = 1'b1;
    end else if (s1_data < SAT_MIN) begin
      sat_data = DW_OUT'(SAT_MIN);
      sat_flag = 1'b1;
    end
  end

  // NOTE: storage has no reset; a bank is only read after it has been fully written.
  always_ff @(posedge clk) begin
    if (wr_en)    mem[{wr_ptr, wr_row, wr_col}] <= bus.in_data;
    if (rd_issue) s1_data <= mem[{rd_ptr, rd_row, rd_col}];
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      bmode_q[0]  <= 2'b00;
      bmode_q[1]  <= 2'b00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      rd_row      <= '0;
      rd_col      <= '0;
      in_ready_q  <= 1'b0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_bank     <= 1'b0;
      s1_mode     <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mode_q  <= 2'b00;
      out_sat_q   <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr     <= wr_ptr_d;
      in_ready_q <= in_ready_d;

      if (wr_en) begin
        if (state_q[wr_ptr] == EMPTY) bmode_q[wr_ptr] <= bus.mode;
        if (wr_col == wr_lim) begin
          wr_col <= '0;
          wr_row <= (wr_row == wr_lim) ? '0 : wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end

      // Column-major drain: the row index moves fastest.
      if (rd_issue) begin
        if (rd_row == rd_lim) begin
          rd_row <= '0;
          rd_col <= (rd_col == rd_lim) ? '0 : rd_col + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
        if (rd_done) rd_ptr <= ~rd_ptr;
      end

      if (s1_adv) begin
        s1_valid <= rd_issue;
        s1_first <= (rd_row == '0) && (rd_col == '0);
        s1_last  <= rd_done;
        s1_mode  <= bmode_q[rd_ptr];
        s1_bank  <= rd_ptr;
      end

      if (out_load) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_data_q  <= sat_data;
          out_sat_q   <= sat_flag;
          out_first_q <= s1_first;
          out_last_q  <= s1_last;
          out_mode_q  <= s1_mode;
          out_bank_q  <= s1_bank;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_idct_transpose.sv
// Randomized bench for idct_transpose: a block-level transpose/saturate model
// feeds an expected-output queue compared against the DUT stream.
module tb_idct_transpose;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idct_transpose_if #(.DW_IN(17), .DW_OUT(16)) bus ();

  idct_transpose #(.DW_IN(17), .DW_OUT(16), .N_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         d;
    bit         f;
    bit         l;
    bit         s;
    logic [1:0] m;
  } exp_t;

  int         n_checks = 0;
  int         n_errs   = 0;
  int         stall_cnt;
  int         in_q[$];
  logic [1:0] md_q[$];
  exp_t       exp_q[$];

  // Reference model: build one block of inputs and its transposed, clamped outputs.
  task automatic gen_block(input logic [1:0] m, input int kind);
    int   n = m[0] ? 8 : 4;
    int   vals[64];
    int   spec[4] = '{32768, -32769, -5, 0};
    exp_t e;
    for (int i = 0; i < n * n; i++) begin
      case (kind)
        0:       vals[i] = i;
        1:       vals[i] = int'($urandom_range(0, 131071)) - 65536;
        default: vals[i] = (i % 4 == 3) ? int'($urandom_range(0, 131071)) - 65536 : spec[i % 4];
      endcase
      in_q.push_back(vals[i]);
    end
    md_q.push_back(m);
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < n; r++) begin
        int v = vals[r * n + c];
        e.d = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
        e.s = (e.d != v);
        e.f = (c == 0 && r == 0);
        e.l = (c == n - 1 && r == n - 1);
        e.m = m;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_blocks(input int nblk, input bit toggle);
    logic [1:0] m = 2'b00;
    int n, v, waits;
    bit acc, started = 0;
    for (int b = 0; b < nblk; b++) begin
      m = md_q.pop_front();
      n = m[0] ? 8 : 4;
      for (int i = 0; i < n * n; i++) begin
        v = in_q.pop_front();
        waits = 0;
        do begin
          bus.mode     = (toggle && i >= 3 && i < 10) ? ((i % 2 == 1) ? 2'b01 : 2'b10) : m;
          bus.in_valid = 1'b1;
          bus.in_data  = 17'(v);
          acc          = bus.in_ready;
          @(posedge clk); #1;
          if (!acc) begin
            waits++;
            if (started) stall_cnt++;
          end
        end while (!acc && waits < 2000);
        if (!acc) begin
          n_checks++; n_errs++;
          $display("FAIL in_ready_timeout block=%0d sample=%0d in_ready=0 required=1", b, i);
          bus.in_valid = 1'b0;
          return;
        end
        started = 1;
      end
    end
    bus.in_valid = 1'b0;
    bus.mode     = m;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready with one 5-cycle hold mid-stream.
  task automatic stream_out(input int total, input int rmode, output int cycles);
    int got = 0, hold = 0, pd = 0;
    bit r, prev_stall = 0, held_once = 0, pf = 0, pl = 0, ps = 0;
    logic [1:0] pm = 2'b00;
    exp_t e;
    cycles = 0;
    while (got < total && cycles < 4000) begin
      case (rmode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          if (got == total / 2 && !held_once) begin
            hold = 5;
            held_once = 1;
          end
          r = (hold == 0);
          if (hold > 0) hold--;
        end
      endcase
      bus.out_ready = r;
      if (prev_stall) begin
        n_checks++;
        if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_sat, bus.out_mode} !== {1'b1, pf, pl, ps, pm}
            || int'($signed(bus.out_data)) !== pd) begin
          n_errs++;
          $display("FAIL stall_hold idx=%0d got v=%b d=%0d f=%b l=%b s=%b m=%b exp v=1 d=%0d f=%b l=%b s=%b m=%b",
                   got, bus.out_valid, $signed(bus.out_data), bus.out_first, bus.out_last, bus.out_sat,
                   bus.out_mode, pd, pf, pl, ps, pm);
        end
      end
      if (bus.out_valid && r) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++;
          $display("FAIL extra_output got d=%0d exp none", $signed(bus.out_data));
        end else begin
          e = exp_q.pop_front();
          if (int'($signed(bus.out_data)) !== e.d || bus.out_first !== e.f || bus.out_last !== e.l
              || bus.out_sat !== e.s || bus.out_mode !== e.m) begin
            n_errs++;
            $display("FAIL sample idx=%0d got d=%0d f=%b l=%b s=%b m=%b exp d=%0d f=%b l=%b s=%b m=%b",
                     got, $signed(bus.out_data), bus.out_first, bus.out_last, bus.out_sat, bus.out_mode,
                     e.d, e.f, e.l, e.s, e.m);
          end
        end
        got++;
      end
      prev_stall = bus.out_valid && !r;
      pd = int'($signed(bus.out_data));
      pf = bus.out_first; pl = bus.out_last; ps = bus.out_sat; pm = bus.out_mode;
      @(posedge clk); #1;
      cycles++;
    end
    bus.out_ready = 1'b0;
    if (got < total) begin
      n_checks++; n_errs++;
      $display("FAIL output_timeout got=%0d exp=%0d", got, total);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last, bus.out_sat} !== 5'b0
        || bus.out_mode !== 2'b00 || bus.out_data !== 16'sd0) begin
      n_errs++;
      $display("FAIL reset_outputs got rdy=%b v=%b f=%b l=%b s=%b m=%b d=%0d exp all zero",
               bus.in_ready, bus.out_valid, bus.out_first, bus.out_last, bus.out_sat, bus.out_mode,
               $signed(bus.out_data));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errs++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_4x4_latency();
    int cyc;
    gen_block(2'b00, 0);
    send_blocks(1, 0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.out_valid !== (k == 2)) begin
        n_errs++;
        $display("FAIL latency edge=E+%0d got out_valid=%b exp=%b", k, bus.out_valid, (k == 2));
      end
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    stream_out(16, 0, cyc);
    n_checks++;
    if (cyc !== 16) begin
      n_errs++;
      $display("FAIL throughput_4x4 got cycles=%0d exp=16", cyc);
    end
  endtask

  task automatic test_8x8();
    int cyc;
    gen_block(2'b01, 0);
    fork
      send_blocks(1, 0);
      stream_out(64, 0, cyc);
    join
  endtask

  task automatic test_saturation();
    int cyc;
    gen_block(2'b00, 2);
    gen_block(2'b01, 2);
    fork
      send_blocks(2, 0);
      stream_out(80, 1, cyc);
    join
  endtask

  task automatic test_backpressure();
    int cyc;
    gen_block(2'b01, 1);
    fork
      send_blocks(1, 0);
      stream_out(64, 2, cyc);
    join
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int b = 0; b < 3; b++) gen_block(2'b01, 1);
    stall_cnt = 0;
    fork
      send_blocks(3, 0);
      stream_out(192, 0, cyc);
    join
    // With a two-stage read pipeline the bank turnaround costs at most two write slots.
    n_checks++;
    if (stall_cnt > 2) begin
      n_errs++;
      $display("FAIL ping_pong_stalls got=%0d exp<=2", stall_cnt);
    end
  endtask

  task automatic test_mode_change();
    int cyc;
    gen_block(2'b00, 1);
    fork
      send_blocks(1, 1);
      stream_out(16, 0, cyc);
    join
    bus.in_valid = 1'b0;
    bus.mode = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errs++;
      $display("FAIL reserved_mode_ready got=%b exp=0", bus.in_ready);
    end
    bus.mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errs++;
      $display("FAIL legal_mode_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_block();
    int cyc, sent = 0, tries = 0;
    bit acc, stale = 0;
    bus.mode = 2'b01;
    while (sent < 20 && tries < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 17'(int'($urandom_range(0, 131071)) - 65536);
      acc = bus.in_ready;
      @(posedge clk); #1;
      tries++;
      if (acc) sent++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_errs++;
      $display("FAIL reset_mid_block got in_ready=%b out_valid=%b exp 0 0", bus.in_ready, bus.out_valid);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    gen_block(2'b00, 1);
    fork
      send_blocks(1, 0);
      stream_out(16, 1, cyc);
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid !== 1'b0) stale = 1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (stale || exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL leftover_after_reset got stale=%b pending=%0d exp 0 0", stale, exp_q.size());
    end
  endtask

  initial begin
    bus.mode      = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    test_reset();
    test_4x4_latency();
    test_8x8();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_mode_change();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
